// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ requesters: registered one-hot
// grant, hold-limit with forced release and blocking, and one idle bubble per handover.
module rr_resource_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   blocked_q, blocked_d;

  logic [N_REQ-1:0]   eligible_s;
  logic [ID_W-1:0]    cand_s;
  logic [ID_W-1:0]    pick_s;
  logic               found_s;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (v == ID_W'(N_REQ - 1)) begin
      return '0;
    end else begin
      return v + ID_W'(1);
    end
  endfunction

  // Next-state logic: rotating priority search in IDLE, hold/release decisions in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    // A requester that lets go of its request earns back eligibility.
    blocked_d  = blocked_q & req;
    eligible_s = req & ~blocked_q;
    cand_s     = '0;
    pick_s     = '0;
    found_s    = 1'b0;

    for (int k = 0; k < N_REQ; k++) begin
      cand_s = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!found_s && eligible_s[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d    = S_GRANT;
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
          gnt_id_d   = pick_s;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (!req[gnt_id_q]) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = wrap_inc(gnt_id_q);
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          blocked_d = blocked_d | gnt_q;
          ptr_d     = wrap_inc(gnt_id_q);
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      blocked_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      blocked_q  <= blocked_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter: each step queues the expected post-edge
// outputs, clocks once, then pops the entry and checks it with immediate assertions.
module tb_rr_resource_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  typedef struct {
    logic [3:0] gnt;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic [3:0] oh_v;

  rr_resource_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    logic [31:0] exp_id;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      exp_id = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (e.gnt[i]) exp_id = i;
      end
      check({e.tag, ".gnt"},     32'(gnt),     32'(e.gnt));
      check({e.tag, ".busy"},    32'(busy),    32'(|e.gnt));
      check({e.tag, ".timeout"}, 32'(timeout), 32'(e.to));
      if (e.gnt != 4'b0000) begin
        check({e.tag, ".gnt_id"}, 32'(gnt_id), exp_id);
      end
    end
  endtask

  // Drive inputs for the next edge, queue the expectation, clock, then compare.
  task automatic step(input logic [3:0] r, input logic rst, input logic [3:0] eg,
                      input logic eto, input string tag);
    exp_t e;
    reset = rst;
    req   = r;
    e.gnt = eg;
    e.to  = eto;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    // Reset with all requests pending, then first grant goes to index 0.
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rst0");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "rst1");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst");
    step(4'b1110, 1'b0, 4'b0000, 1'b0, "rel0");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");

    // Single requester.
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "single_gnt");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "single_hold1");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "single_hold2");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "single_rel");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "single_noto");

    // Round robin 0,1,2,3,0 with one bubble between grants.
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "rr_rst");
    for (int k = 0; k < 4; k++) begin
      oh_v = 4'b0001 << k;
      step(4'b1111, 1'b0, oh_v, 1'b0, $sformatf("rr_gnt%0d", k));
      step(4'b1111, 1'b0, oh_v, 1'b0, $sformatf("rr_hold%0d", k));
      step(4'b1111 & ~oh_v, 1'b0, 4'b0000, 1'b0, $sformatf("rr_bubble%0d", k));
    end
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_wrap");
    step(4'b1110, 1'b0, 4'b0000, 1'b0, "rr_end");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "rr_idle");

    // Timeouts and blocking.
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "to_rst");
    for (int c = 0; c < 8; c++) step(4'b0011, 1'b0, 4'b0001, 1'b0, $sformatf("to_own0_%0d", c));
    step(4'b0011, 1'b0, 4'b0000, 1'b1, "to_pulse0");
    for (int c = 0; c < 8; c++) step(4'b0011, 1'b0, 4'b0010, 1'b0, $sformatf("to_own1_%0d", c));
    step(4'b0011, 1'b0, 4'b0000, 1'b1, "to_pulse1");
    for (int c = 0; c < 3; c++) step(4'b0011, 1'b0, 4'b0000, 1'b0, $sformatf("to_blocked%0d", c));
    step(4'b0010, 1'b0, 4'b0000, 1'b0, "to_drop0");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "to_regrant0");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_rel");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_idle");

    // Owner 1 drops exactly at the hold limit; req[3] arrives meanwhile.
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "edge_gnt1");
    for (int c = 0; c < 7; c++) step(4'b1010, 1'b0, 4'b0010, 1'b0, $sformatf("edge_hold%0d", c));
    step(4'b1000, 1'b0, 4'b0000, 1'b0, "edge_rel_noto");
    step(4'b1000, 1'b0, 4'b1000, 1'b0, "edge_gnt3");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "edge_rel3");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "edge_unblocked1");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "edge_hold_again");

    // Reset mid-grant clears outputs and the pointer.
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "mid_rel");
    step(4'b1000, 1'b0, 4'b1000, 1'b0, "mid_gnt3");
    step(4'b1000, 1'b0, 4'b1000, 1'b0, "mid_hold3");
    step(4'b1000, 1'b1, 4'b0000, 1'b0, "mid_rst");
    step(4'b1001, 1'b0, 4'b0001, 1'b0, "mid_ptr0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
